// File: rtl/wavegen_multi.sv
// Multi-mode waveform generator driven by an internal phase accumulator.
// Define WAVEGEN_MOD_EN to build the modulated-square mode (mode 5) and its period counter.
module wavegen_multi #(
  parameter int WIDTH     = 8,
  parameter int PHASE_W   = 16,
  parameter int MOD_DIV_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [PHASE_W-1:0] freq_step,
  input  logic [2:0]         mode_in,
  input  logic [WIDTH-1:0]   duty_in,
  input  logic [1:0]         amp_shift,
  input  logic               load,
  output logic [WIDTH-1:0]   signal,
  output logic               wrap,
  output logic [2:0]         active_mode
);

  if (WIDTH < 4 || PHASE_W < WIDTH || MOD_DIV_W < 1) begin : g_param_check
    $error("wavegen_multi: illegal parameter combination");
  end

  localparam logic [WIDTH-1:0] DUTY_RST = WIDTH'(1) << (WIDTH - 1);

  logic [PHASE_W-1:0] acc, acc_next;
  logic [PHASE_W:0]   sum;
  logic               carry;
  logic [2:0]         shadow_mode, mode_eff;
  logic [WIDTH-1:0]   shadow_duty, active_duty, duty_eff;
  logic               pending, xfer;
  logic [WIDTH-1:0]   ph, sq, tri_s, shape;

`ifdef WAVEGEN_MOD_EN
  logic [MOD_DIV_W-1:0] mod_cnt, mod_next;
  assign mod_next = carry ? mod_cnt + 1'b1 : mod_cnt;

  always_ff @(posedge clk) begin
    if (rst) mod_cnt <= '0;
    else     mod_cnt <= mod_next;
  end
`endif

  always_comb begin
    sum      = {1'b0, acc} + {1'b0, freq_step};
    acc_next = acc;
    carry    = 1'b0;
    if (en) begin
      acc_next = sum[PHASE_W-1:0];
      carry    = sum[PHASE_W];
    end
    // Shadow settings take over at the period boundary, or at once while the phase is frozen.
    xfer     = pending && (carry || !en);
    mode_eff = xfer ? shadow_mode : active_mode;
    duty_eff = xfer ? shadow_duty : active_duty;

    ph    = acc_next[PHASE_W-1 -: WIDTH];
    sq    = (ph < duty_eff) ? '1 : '0;
    tri_s = {ph[WIDTH-2:0], 1'b0};
    if (ph[WIDTH-1]) tri_s = ~tri_s;

    shape = '0;
    case (mode_eff)
      3'd0:    shape = sq;
      3'd1:    shape = ph;
      3'd2:    shape = ~ph;
      3'd3:    shape = tri_s;
`ifdef WAVEGEN_MOD_EN
      3'd5:    shape = mod_next[MOD_DIV_W-1] ? sq : '0;
`endif
      default: shape = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc         <= '0;
      wrap        <= 1'b0;
      signal      <= '0;
      active_mode <= 3'd0;
      active_duty <= DUTY_RST;
      shadow_mode <= 3'd0;
      shadow_duty <= DUTY_RST;
      pending     <= 1'b0;
    end else begin
      acc         <= acc_next;
      wrap        <= carry;
      signal      <= shape >> amp_shift;
      active_mode <= mode_eff;
      active_duty <= duty_eff;
      if (load) begin
        shadow_mode <= mode_in;
        shadow_duty <= duty_in;
      end
      // A load coinciding with a transfer stays pending for the next boundary.
      pending <= load || (pending && !xfer);
    end
  end

endmodule

// File: tb/tb_wavegen_multi.sv
// Directed bench for wavegen_multi (default parameters, modulation feature not built).
module tb_wavegen_multi;

  logic        clk = 1'b0;
  logic        rst, en, load, wrap;
  logic [15:0] freq_step;
  logic [2:0]  mode_in, active_mode;
  logic [7:0]  duty_in, signal;
  logic [1:0]  amp_shift;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  wavegen_multi #(.WIDTH(8), .PHASE_W(16), .MOD_DIV_W(4)) dut (
    .clk(clk), .rst(rst), .en(en), .freq_step(freq_step), .mode_in(mode_in),
    .duty_in(duty_in), .amp_shift(amp_shift), .load(load), .signal(signal),
    .wrap(wrap), .active_mode(active_mode)
  );

  typedef struct {
    logic        rst, en, load;
    logic [15:0] step;
    logic [2:0]  mode;
    logic [7:0]  duty;
    logic [1:0]  amp;
    logic [7:0]  exp_sig;
    logic        exp_wrap;
    logic [2:0]  exp_mode;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic e, input logic l, input logic [15:0] s,
                     input logic [2:0] m, input logic [7:0] d, input logic [1:0] a,
                     input logic [7:0] xs, input logic xw, input logic [2:0] xm);
    vec_t v;
    v.rst = r; v.en = e; v.load = l; v.step = s; v.mode = m; v.duty = d; v.amp = a;
    v.exp_sig = xs; v.exp_wrap = xw; v.exp_mode = xm;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic r, input logic e, input logic l, input logic [15:0] s,
                       input logic [2:0] m, input logic [7:0] d, input logic [1:0] a);
    rst = r; en = e; load = l; freq_step = s; mode_in = m; duty_in = d; amp_shift = a;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] xs, input logic xw,
                       input logic [2:0] xm);
    n_vec++;
    if (signal !== xs || wrap !== xw || active_mode !== xm) begin
      n_bad++;
      $display("FAIL %s: got signal=%0d wrap=%0b mode=%0d, want signal=%0d wrap=%0b mode=%0d",
               name, signal, wrap, active_mode, xs, xw, xm);
    end
  endtask

  // Select a shape from reset: load while frozen, then one frozen cycle to transfer.
  task automatic start_mode(input logic [2:0] m, input logic [7:0] d);
    drive(1, 0, 0, 16'h0, 3'd0, 8'd0, 2'd0);
    drive(0, 0, 1, 16'h0, m, d, 2'd0);
    drive(0, 0, 0, 16'h0, 3'd0, 8'd0, 2'd0);
    n_vec++;
    if (active_mode !== m) begin
      n_bad++;
      $display("FAIL start_mode: got mode=%0d, want %0d", active_mode, m);
    end
  endtask

  initial begin
    int  highs;
    int  ph;
    logic [7:0] xs;

    rst = 1; en = 0; load = 0; freq_step = '0; mode_in = '0; duty_in = '0; amp_shift = '0;

    //  rst en ld step      mode  duty  amp  sig  wrap mode
    add(1, 1, 1, 16'h1234, 3'd3, 8'd7,   2'd1, 8'd0,   0, 3'd0);
    add(1, 0, 0, 16'hFFFF, 3'd2, 8'd99,  2'd3, 8'd0,   0, 3'd0);
    add(0, 0, 1, 16'h0100, 3'd1, 8'd64,  2'd0, 8'd255, 0, 3'd0);
    add(0, 0, 0, 16'h0100, 3'd0, 8'd0,   2'd0, 8'd0,   0, 3'd1);
    add(0, 1, 0, 16'h0100, 3'd0, 8'd0,   2'd0, 8'd1,   0, 3'd1);
    add(0, 1, 0, 16'h0100, 3'd0, 8'd0,   2'd1, 8'd1,   0, 3'd1);
    add(0, 1, 0, 16'h3E00, 3'd0, 8'd0,   2'd0, 8'd64,  0, 3'd1);
    add(0, 1, 0, 16'hC000, 3'd0, 8'd0,   2'd0, 8'd0,   1, 3'd1);
    add(0, 1, 0, 16'hFFFF, 3'd0, 8'd0,   2'd0, 8'd255, 0, 3'd1);
    add(0, 1, 0, 16'h0001, 3'd0, 8'd0,   2'd0, 8'd0,   1, 3'd1);
    add(0, 1, 0, 16'h0000, 3'd0, 8'd0,   2'd0, 8'd0,   0, 3'd1);
    add(0, 0, 0, 16'h0100, 3'd0, 8'd0,   2'd0, 8'd0,   0, 3'd1);
    add(0, 0, 1, 16'h0100, 3'd2, 8'd200, 2'd0, 8'd0,   0, 3'd1);
    add(0, 1, 0, 16'h8000, 3'd0, 8'd0,   2'd0, 8'd128, 0, 3'd1);
    add(0, 1, 0, 16'h8100, 3'd0, 8'd0,   2'd0, 8'd254, 1, 3'd2);
    add(0, 1, 1, 16'h3F00, 3'd3, 8'd200, 2'd0, 8'd191, 0, 3'd2);
    add(0, 1, 1, 16'hC000, 3'd0, 8'd10,  2'd0, 8'd0,   1, 3'd3);
    add(0, 1, 0, 16'h0500, 3'd0, 8'd0,   2'd0, 8'd10,  0, 3'd3);
    add(0, 1, 0, 16'hFB00, 3'd0, 8'd0,   2'd0, 8'd255, 1, 3'd0);
    add(0, 1, 0, 16'h0A00, 3'd0, 8'd0,   2'd0, 8'd0,   0, 3'd0);
    add(1, 1, 1, 16'h0100, 3'd1, 8'd5,   2'd0, 8'd0,   0, 3'd0);
    add(0, 0, 0, 16'h0100, 3'd0, 8'd0,   2'd0, 8'd255, 0, 3'd0);
    add(0, 0, 1, 16'h0100, 3'd5, 8'd128, 2'd0, 8'd255, 0, 3'd0);
    add(0, 0, 0, 16'h0100, 3'd0, 8'd0,   2'd0, 8'd0,   0, 3'd5);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].en, vecs[i].load, vecs[i].step, vecs[i].mode,
            vecs[i].duty, vecs[i].amp);
      check($sformatf("vec%0d", i), vecs[i].exp_sig, vecs[i].exp_wrap, vecs[i].exp_mode);
    end

    // Sawtooth: one full period, wrap coincides with the sample returning to 0.
    start_mode(3'd1, 8'd128);
    for (int k = 1; k <= 256; k++) begin
      drive(0, 1, 0, 16'h0100, 3'd0, 8'd0, 2'd0);
      check($sformatf("saw%0d", k), 8'(k % 256), (k == 256), 3'd1);
    end

    // Triangle with amplitude shift 2: independent piecewise model.
    start_mode(3'd3, 8'd128);
    for (int k = 1; k <= 128; k++) begin
      drive(0, 1, 0, 16'h0200, 3'd0, 8'd0, 2'd2);
      ph = (2 * k) % 256;
      xs = (ph < 128) ? 8'(2 * ph) : 8'(255 - 2 * (ph - 128));
      check($sformatf("tri%0d", k), xs >> 2, (k == 128), 3'd3);
    end

    // Square duty 64 and duty 0: count high samples over one period.
    for (int pass = 0; pass < 2; pass++) begin
      start_mode(3'd0, (pass == 0) ? 8'd64 : 8'd0);
      highs = 0;
      for (int k = 1; k <= 256; k++) begin
        drive(0, 1, 0, 16'h0100, 3'd0, 8'd0, 2'd0);
        if (signal == 8'd255) highs++;
        else if (signal != 8'd0) highs += 1000;
      end
      n_vec++;
      if (highs != ((pass == 0) ? 64 : 0)) begin
        n_bad++;
        $display("FAIL square_highs duty%0d: got %0d, want %0d",
                 (pass == 0) ? 64 : 0, highs, (pass == 0) ? 64 : 0);
      end
    end

    // Load on the wrap cycle: previous shadow applies now, new one a period later.
    start_mode(3'd1, 8'd128);
    drive(0, 1, 0, 16'hFF00, 3'd0, 8'd0, 2'd0);
    check("wl_pre", 8'd255, 0, 3'd1);
    drive(0, 1, 1, 16'h0100, 3'd2, 8'd128, 2'd0);
    check("wl_wrap", 8'd0, 1, 3'd1);
    drive(0, 1, 0, 16'h0100, 3'd0, 8'd0, 2'd0);
    check("wl_after", 8'd1, 0, 3'd1);
    drive(0, 1, 0, 16'hFF00, 3'd0, 8'd0, 2'd0);
    check("wl_next_wrap", 8'd255, 1, 3'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
